// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and IF/ID outputs.
// misalign_o exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_stage_if;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic [63:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [63:0] ifid_pc_o;
    logic [63:0] ifid_pc_plus4_o;
    logic        halted_o;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    modport master (
        input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
        output imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc_plus4_o,
`ifdef FETCH_ALIGN_CHECK_EN
        output misalign_o,
`endif
        output halted_o
    );

    modport slave (
        output stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
        input  imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc_plus4_o,
`ifdef FETCH_ALIGN_CHECK_EN
        input  misalign_o,
`endif
        input  halted_o
    );
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, zero-latency imem port, IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN: force redirect targets word-aligned and flag it (sticky misalign_o).
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter logic [63:0] END_PC   = 64'd40
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic [63:0] target;
    logic        halted;

    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [63:0] ifid_pc;
    logic [63:0] ifid_pc_plus4;

    assign pc_plus4 = pc + 64'd4;
    assign halted   = (pc >= END_PC);

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign;
    logic target_misaligned;

    assign target            = {bus.redirect_pc_i[63:2], 2'b00};
    assign target_misaligned = |bus.redirect_pc_i[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if (bus.redirect_i && target_misaligned) begin
            misalign <= 1'b1;
        end
    end

    assign bus.misalign_o = misalign;
`else
    assign target = bus.redirect_pc_i;
`endif

    // Program counter: redirect > stall > (advance unless halted).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (bus.redirect_i) begin
            pc <= target;
        end else if (bus.stall_i) begin
            pc <= pc;
        end else if (!halted) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID: captures only on a clean cycle; stall without flush holds, everything else bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus4 <= '0;
        end else if (bus.redirect_i) begin
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus4 <= '0;
        end else if (bus.stall_i && !bus.flush_i) begin
            ifid_valid    <= ifid_valid;
        end else if (bus.stall_i || bus.flush_i || halted) begin
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus4 <= '0;
        end else begin
            ifid_valid    <= 1'b1;
            ifid_instr    <= bus.imem_data_i;
            ifid_pc       <= pc;
            ifid_pc_plus4 <= pc_plus4;
        end
    end

    assign bus.imem_addr_o     = pc;
    assign bus.halted_o        = halted;
    assign bus.ifid_valid_o    = ifid_valid;
    assign bus.ifid_instr_o    = ifid_instr;
    assign bus.ifid_pc_o       = ifid_pc;
    assign bus.ifid_pc_plus4_o = ifid_pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk-through with literal expectations, then randomized
// stall/flush/redirect/reset traffic checked every cycle against a behavioural model.
module tb_fetch_stage;

    localparam logic [63:0] END_PC = 64'd40;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   cmp_en;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(64'd0), .END_PC(END_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte-addressed program memory, big-endian words, index wraps at 256 bytes.
    logic [7:0] mem [256];

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        logic [7:0] i;
        i = a[7:0];
        return {mem[i], mem[i + 8'd1], mem[i + 8'd2], mem[i + 8'd3]};
    endfunction

    always_comb bus.imem_data_i = imem_word(bus.imem_addr_o);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: next state straight from the priority rules.
    logic [63:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_ipc;
    logic        m_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 64'd0; m_valid = 1'b0; m_instr = '0; m_ipc = '0; m_mis = 1'b0;
        end else if (bus.redirect_i) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (bus.redirect_pc_i % 4 != 0) m_mis = 1'b1;
            m_pc = bus.redirect_pc_i - (bus.redirect_pc_i % 4);
`else
            m_pc = bus.redirect_pc_i;
`endif
            m_valid = 1'b0; m_instr = '0; m_ipc = '0;
        end else begin
            bit hlt, capture, hold;
            hlt     = (m_pc >= END_PC);
            capture = !bus.stall_i && !bus.flush_i && !hlt;
            hold    = bus.stall_i && !bus.flush_i;
            if (capture) begin
                m_valid = 1'b1; m_instr = imem_word(m_pc); m_ipc = m_pc;
            end else if (!hold) begin
                m_valid = 1'b0; m_instr = '0; m_ipc = '0;
            end
            if (!bus.stall_i && !hlt) m_pc = m_pc + 64'd4;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid",  64'(bus.ifid_valid_o), 64'(m_valid));
            chk("instr",  64'(bus.ifid_instr_o), 64'(m_instr));
            chk("pc",     bus.ifid_pc_o, m_ipc);
            chk("pc4",    bus.ifid_pc_plus4_o, m_valid ? m_ipc + 64'd4 : 64'd0);
            chk("addr",   bus.imem_addr_o, m_pc);
            chk("halted", 64'(bus.halted_o), 64'(m_pc >= END_PC));
`ifdef FETCH_ALIGN_CHECK_EN
            chk("misalign", 64'(bus.misalign_o), 64'(m_mis));
`endif
        end
    end

    // Set inputs, let one rising edge pass, return shortly after it.
    task automatic drive(input bit s, input bit f, input bit r, input logic [63:0] t);
        bus.stall_i = s; bus.flush_i = f; bus.redirect_i = r; bus.redirect_pc_i = t;
        @(posedge clk);
        #2;
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.ifid_valid_o), 64'd0);
        chk("rst_addr",  bus.imem_addr_o, 64'd0);
        chk("rst_pc",    bus.ifid_pc_o, 64'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_misalign", 64'(bus.misalign_o), 64'd0);
`endif
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        total = 0; bad = 0; cmp_en = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        {mem[0], mem[1], mem[2], mem[3]} = 32'hF842_8005;
        {mem[4], mem[5], mem[6], mem[7]} = 32'hF845_000A;

        rst_n = 1'b0;
        bus.stall_i = 0; bus.flush_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = '0;
        #1;
        chk("reset_valid",  64'(bus.ifid_valid_o), 64'd0);
        chk("reset_instr",  64'(bus.ifid_instr_o), 64'd0);
        chk("reset_pc4",    bus.ifid_pc_plus4_o, 64'd0);
        chk("reset_halted", 64'(bus.halted_o), 64'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        cmp_en = 1;

        drive(0, 0, 0, 64'hFFFF);
        chk("e1_valid", 64'(bus.ifid_valid_o), 64'd1);
        chk("e1_instr", 64'(bus.ifid_instr_o), 64'hF842_8005);
        chk("e1_pc",    bus.ifid_pc_o, 64'd0);
        chk("e1_pc4",   bus.ifid_pc_plus4_o, 64'd4);
        drive(0, 0, 0, 64'd0);
        chk("e2_instr", 64'(bus.ifid_instr_o), 64'hF845_000A);
        chk("e2_pc",    bus.ifid_pc_o, 64'd4);
        chk("e2_addr",  bus.imem_addr_o, 64'd8);

        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 64'd0);
            chk("stall_addr",  bus.imem_addr_o, 64'd8);
            chk("stall_pc",    bus.ifid_pc_o, 64'd4);
            chk("stall_instr", 64'(bus.ifid_instr_o), 64'hF845_000A);
        end
        drive(0, 0, 0, 64'd0);
        chk("unstall_pc", bus.ifid_pc_o, 64'd8);

        drive(1, 0, 1, 64'h18);
        chk("redir_valid", 64'(bus.ifid_valid_o), 64'd0);
        chk("redir_addr",  bus.imem_addr_o, 64'h18);
        drive(0, 0, 0, 64'd0);
        chk("redir_next_valid", 64'(bus.ifid_valid_o), 64'd1);
        chk("redir_next_pc",    bus.ifid_pc_o, 64'h18);

        drive(0, 0, 1, 64'h10);
        drive(0, 1, 0, 64'd0);
        chk("flush_valid", 64'(bus.ifid_valid_o), 64'd0);
        chk("flush_instr", 64'(bus.ifid_instr_o), 64'd0);
        chk("flush_addr",  bus.imem_addr_o, 64'h14);

        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            drive(0, 0, 0, 64'd0);
            if (bus.ifid_valid_o && bus.ifid_pc_o == 64'd36) found = 1;
        end
        chk("reach_pc36", 64'(found), 64'd1);
        chk("halt_flag",  64'(bus.halted_o), 64'd1);
        chk("halt_addr",  bus.imem_addr_o, 64'd40);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 64'd0);
            chk("halt_valid", 64'(bus.ifid_valid_o), 64'd0);
            chk("halt_hold",  bus.imem_addr_o, 64'd40);
        end
        drive(0, 0, 1, 64'd0);
        chk("unhalt_flag", 64'(bus.halted_o), 64'd0);
        chk("unhalt_addr", bus.imem_addr_o, 64'd0);
        drive(0, 0, 0, 64'd0);
        chk("resume_valid", 64'(bus.ifid_valid_o), 64'd1);
        chk("resume_pc",    bus.ifid_pc_o, 64'd0);

`ifdef FETCH_ALIGN_CHECK_EN
        drive(0, 0, 1, 64'h1A);
        chk("align_addr", bus.imem_addr_o, 64'h18);
        chk("align_flag", 64'(bus.misalign_o), 64'd1);
        drive(0, 0, 1, 64'h20);
        chk("align_sticky", 64'(bus.misalign_o), 64'd1);
`endif
        mid_reset();
        drive(0, 0, 0, 64'd0);
        chk("post_rst_pc", bus.ifid_pc_o, 64'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [63:0] t;
            t = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                             : 64'($urandom_range(0, 52));
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 11) == 0, t);
            if ($urandom_range(0, 299) == 0) mid_reset();
        end
        bus.stall_i = 0; bus.flush_i = 0; bus.redirect_i = 0;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
